// File: rtl/mem_stage_sequencer.sv
// mem_stage_sequencer: LC-3b MEM-stage access sequencer (word/byte/indirect), MEM_SEQ_STATS_EN adds stall and indirect-op counters
module mem_stage_sequencer #(
  parameter int DATA_W = 16,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              dmem_resp,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [1:0]        dmem_byte_en,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] load_data
`ifdef MEM_SEQ_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall_cycles,
  output logic [STAT_W-1:0] stat_indirect_ops
`endif
);
  typedef enum logic [1:0] {IDLE, PTR, DATA, DONE} state_t;
  state_t state;
  logic [3:0] op;
  logic [DATA_W-1:0] a, sd;
  logic mem_op, st, byt, req, byte_data;
  logic [7:0] lane;
  always_comb begin
    mem_op = opcode inside {4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1010, 4'b1011};
    st = op[0];
    byt = op[3:1] == 3'b001;
    req = state == PTR || state == DATA;
    byte_data = state == DATA && byt;
    lane = a[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
    dmem_read = state == PTR || (state == DATA && !st);
    dmem_write = state == DATA && st;
    dmem_addr = !req ? '0 : byte_data ? a : {a[DATA_W-1:1], 1'b0};
    dmem_byte_en = !req ? 2'b00 : byte_data ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    dmem_wdata = state != DATA ? '0 : byt ? {sd[7:0], sd[7:0]} : sd;
    stall = rst_n && ((state == IDLE && valid && mem_op) || req);
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op <= '0;
      a <= '0;
      sd <= '0;
      load_data <= '0;
    end else begin
      case (state)
        IDLE: if (valid && mem_op) begin
          op <= opcode;
          a <= addr;
          sd <= store_data;
          state <= opcode[3] ? PTR : DATA;
        end
        PTR: if (dmem_resp) begin
          a <= dmem_rdata;
          state <= DATA;
        end
        DATA: if (dmem_resp) begin
          load_data <= st ? load_data : byt ? {{(DATA_W-8){lane[7]}}, lane} : dmem_rdata;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef MEM_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cycles <= '0;
      stat_indirect_ops <= '0;
    end else begin
      if (stall && stat_stall_cycles != '1) stat_stall_cycles <= stat_stall_cycles + 1'b1;
      if (state == IDLE && valid && mem_op && opcode[3] && stat_indirect_ops != '1)
        stat_indirect_ops <= stat_indirect_ops + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_stage_sequencer.sv
// tb_mem_stage_sequencer: randomized self-checking bench for mem_stage_sequencer against a transaction-level model
module tb_mem_stage_sequencer;
  localparam int W = 16;
  logic clk = 0, rst_n = 0, valid = 0, dmem_resp = 0;
  logic [3:0] opcode = 0;
  logic [W-1:0] addr = 0, store_data = 0, dmem_rdata = 0;
  logic dmem_read, dmem_write, stall, done;
  logic [W-1:0] dmem_addr, dmem_wdata, load_data;
  logic [1:0] dmem_byte_en;
  int checks = 0, errors = 0;
  logic [W-1:0] model_ld = 0;
`ifdef MEM_SEQ_STATS_EN
  logic [15:0] stat_stall_cycles, stat_indirect_ops;
  int model_stall = 0, model_ind = 0;
`endif
  mem_stage_sequencer #(.DATA_W(W), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .opcode(opcode), .addr(addr),
    .store_data(store_data), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en), .stall(stall),
    .done(done), .load_data(load_data)
`ifdef MEM_SEQ_STATS_EN
    , .stat_stall_cycles(stat_stall_cycles), .stat_indirect_ops(stat_indirect_ops)
`endif
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check_stats(input string tag);
`ifdef MEM_SEQ_STATS_EN
    checks++;
    if ({stat_stall_cycles, stat_indirect_ops} !== {16'(model_stall), 16'(model_ind)}) begin
      errors++;
      $display("FAIL %s stats: got stall=%0d ind=%0d want stall=%0d ind=%0d", tag,
               stat_stall_cycles, stat_indirect_ops, model_stall, model_ind);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask
  task automatic access(input bit rd, input logic [W-1:0] ea, input logic [1:0] be,
                        input logic [W-1:0] wd, input logic [W-1:0] rdata, input int waits,
                        input string tag);
    logic [37:0] got, exp;
    for (int c = 0; c <= waits; c++) begin
      got = {dmem_read, dmem_write, dmem_addr, dmem_byte_en, dmem_write ? dmem_wdata : 16'h0, stall, done};
      exp = {rd, !rd, ea, be, rd ? 16'h0 : wd, 1'b1, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d {rd,wr,addr,be,wdata,stall,done}: got %h want %h", tag, c, got, exp);
      end
      dmem_resp = c == waits;
      dmem_rdata = c == waits ? rdata : W'($urandom);
      step();
    end
    dmem_resp = 0;
  endtask
  task automatic do_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] sd,
                       input logic [W-1:0] r0, input logic [W-1:0] r1, input int w0,
                       input int w1, input string tag);
    bit mem, ind, st, byt;
    logic [W-1:0] daddr;
    logic [1:0] be;
    logic [7:0] b;
    mem = o inside {4'h2, 4'h3, 4'h6, 4'h7, 4'hA, 4'hB};
    ind = o inside {4'hA, 4'hB};
    byt = o inside {4'h2, 4'h3};
    st = o[0];
    valid = 1;
    opcode = o;
    addr = a;
    store_data = sd;
    if (done === 1'b1) step();
    #1;
    checks++;
    if ({stall, dmem_read, dmem_write, done} !== {mem, 3'b000}) begin
      errors++;
      $display("FAIL %s accept {stall,rd,wr,done}: got %b want %b", tag,
               {stall, dmem_read, dmem_write, done}, {mem, 3'b000});
    end
    step();
    if (!mem) begin
      checks++;
      if ({stall, dmem_read, dmem_write, done} !== 4'b0000) begin
        errors++;
        $display("FAIL %s nonmem hold {stall,rd,wr,done}: got %b want 0000", tag,
                 {stall, dmem_read, dmem_write, done});
      end
      valid = 0;
      return;
    end
`ifdef MEM_SEQ_STATS_EN
    model_stall += 1 + (ind ? w0 + 1 : 0) + w1 + 1;
    if (ind) model_ind++;
`endif
    valid = 0;
    opcode = 4'($urandom);
    addr = W'($urandom);
    store_data = W'($urandom);
    if (ind) access(1'b1, {a[W-1:1], 1'b0}, 2'b11, '0, r0, w0, {tag, "/ptr"});
    daddr = ind ? {r0[W-1:1], 1'b0} : byt ? a : {a[W-1:1], 1'b0};
    be = byt ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    access(!st, daddr, be, byt ? {sd[7:0], sd[7:0]} : sd, r1, w1, {tag, "/data"});
    b = a[0] ? r1[15:8] : r1[7:0];
    if (!st) model_ld = byt ? {{8{b[7]}}, b} : r1;
    checks++;
    if ({stall, dmem_read, dmem_write, done, load_data} !== {4'b0001, model_ld}) begin
      errors++;
      $display("FAIL %s done {stall,rd,wr,done}=%b load_data=%h want 0001 %h", tag,
               {stall, dmem_read, dmem_write, done}, load_data, model_ld);
    end
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if ({dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_en, stall, done, load_data} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got rd=%b wr=%b addr=%h wd=%h be=%b stall=%b done=%b ld=%h want all 0",
               dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_en, stall, done, load_data);
    end
    check_stats("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    step();
  endtask
  task automatic test_word();
    do_op(4'b0110, 16'h1235, 16'h0, 16'h0, 16'hBEEF, 0, 2, "ldr_wait2");
    step();
    do_op(4'b0111, 16'h0F0F, 16'hA5A5, 16'h0, 16'h0, 0, 0, "str_0wait");
  endtask
  task automatic test_byte();
    do_op(4'b0010, 16'h2001, 16'h0, 16'h0, 16'h80AA, 0, 1, "ldb_hi");
    do_op(4'b0010, 16'h2000, 16'h0, 16'h0, 16'h80AA, 0, 0, "ldb_lo");
  endtask
  task automatic test_store_byte();
    step();
    do_op(4'b0011, 16'h3001, 16'h12C3, 16'h0, 16'h0, 0, 1, "stb_hi");
    do_op(4'b0011, 16'h3000, 16'h0081, 16'h0, 16'h0, 0, 0, "stb_lo");
  endtask
  task automatic test_indirect();
    step();
    do_op(4'b1010, 16'h4000, 16'h0, 16'h5006, 16'h0042, 1, 1, "ldi");
    step();
    do_op(4'b1011, 16'h4000, 16'h7777, 16'h5006, 16'h0, 0, 2, "sti");
    do_op(4'b1010, 16'h4001, 16'h0, 16'h6003, 16'hFFFE, 2, 0, "ldi_odd");
    check_stats("indirect");
  endtask
  task automatic test_back_to_back();
    step();
    do_op(4'b0001, 16'h1234, 16'h5555, 16'h0, 16'h0, 0, 0, "add_nonmem");
    do_op(4'b0110, 16'h0100, 16'h0, 16'h0, 16'h1357, 0, 0, "b2b_ldr");
    do_op(4'b0111, 16'h0102, 16'h2468, 16'h0, 16'h0, 0, 1, "b2b_str");
    do_op(4'b0000, 16'h0200, 16'h0, 16'h0, 16'h0, 0, 0, "br_after_done");
  endtask
  task automatic test_reset_mid();
    step();
    valid = 1;
    opcode = 4'b0110;
    addr = 16'h1111;
    step();
    checks++;
    if ({dmem_read, stall} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid pre {rd,stall}: got %b want 11", {dmem_read, stall});
    end
    #1 rst_n = 0;
    #1;
    model_ld = 0;
`ifdef MEM_SEQ_STATS_EN
    model_stall = 0;
    model_ind = 0;
`endif
    checks++;
    if ({dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_en, stall, done, load_data} !== '0) begin
      errors++;
      $display("FAIL rst_mid outputs: got rd=%b wr=%b addr=%h wd=%h be=%b stall=%b done=%b ld=%h want all 0",
               dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_en, stall, done, load_data);
    end
    check_stats("rst_mid");
    valid = 0;
    @(negedge clk);
    rst_n = 1;
    step();
    do_op(4'b0110, 16'h0ABC, 16'h0, 16'h0, 16'h600D, 0, 1, "post_rst_ldr");
    check_stats("post_rst");
  endtask
  task automatic test_random();
    logic [3:0] ops [8];
    ops = '{4'h2, 4'h3, 4'h6, 4'h7, 4'hA, 4'hB, 4'h1, 4'h5};
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) step();
      do_op(ops[$urandom_range(0, 7)], W'($urandom), W'($urandom), W'($urandom), W'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rand%0d", i));
    end
    check_stats("random");
  endtask
  initial begin
    test_reset();
    test_word();
    test_byte();
    test_store_byte();
    test_indirect();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
